mem_unit: RTL and testbench
===========================

MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 SHALL have port: clk  in  1  system clock; all state updates on the rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: fetch  in  1  address select: 1 = pc, 0 = opaddr.
REQ-004 SHALL have port: store_mem  in  1  write request; effective only when fetch=0.
REQ-005 SHALL have port: pc  in  8  program-counter address.
REQ-006 SHALL have port: opaddr  in  8  operand address (lower instruction byte).
REQ-007 SHALL have port: wdata  in  8  write data (accumulator value).
REQ-008 SHALL have port: mdr  out  8  registered read data.
REQ-009 SHALL have port: ld_start  in  1  begin a program load at address 0.
REQ-010 SHALL have port: ld_len  in  8  load length in bytes, sampled with ld_start; 0 means 256.
REQ-011 SHALL have port: ld_valid  in  1  load byte valid.
REQ-012 SHALL have port: ld_data  in  8  load byte.
REQ-013 SHALL have port: ld_ready  out  1  ready to accept a load byte.
REQ-014 SHALL have port: boot_skip  in  1  enter RUN from IDLE without loading.
REQ-015 SHALL have port: cpu_hold  out  1  holds the control unit in reset while high.
REQ-016 SHALL have port: ld_done  out  1  one-cycle pulse at load completion.
REQ-017 SHALL have port: mstate  out  2  current state encoding (IDLE=0, LOAD=1, DONE=2, RUN=3).

Function
REQ-018 SHALL contain a 256x8 storage array; the array SHALL NOT be cleared by reset.
REQ-019 SHALL implement states IDLE, LOAD, DONE and RUN.
REQ-020 IDLE SHALL transition to LOAD on ld_start, otherwise to RUN on boot_skip; ld_start SHALL win when both are high.
REQ-021 On entering LOAD, the block SHALL set the write pointer to 0 and latch the remaining count to ld_len (0 -> 256).
REQ-022 In LOAD, ld_ready SHALL be 1, and each cycle with ld_valid=1 SHALL write ld_data to mem[ptr], then increment ptr and decrement the count.
REQ-023 In LOAD, ld_valid=0 SHALL stall the load; ptr and the count SHALL hold.
REQ-024 When the last byte is accepted (count 1 -> 0), the block SHALL transition to DONE; ptr SHALL wrap 255 -> 0 only for a 256-byte load.
REQ-025 DONE SHALL last exactly one cycle with ld_done=1, then transition to RUN.
REQ-026 cpu_hold SHALL be 1 in IDLE, LOAD and DONE, and 0 only in RUN.
REQ-027 ld_ready SHALL be 0 outside LOAD; ld_valid outside LOAD SHALL be ignored.
REQ-028 In RUN, every rising edge SHALL update mdr with mem[addr], where addr = fetch ? pc : opaddr.
REQ-029 In RUN, store_mem=1 with fetch=0 SHALL write wdata to mem[opaddr].
REQ-030 store_mem=1 with fetch=1 SHALL NOT write the array.
REQ-031 A read and a write to the same address on the same edge SHALL return the old data in mdr (read-before-write); the new data SHALL be visible on the next edge.
REQ-032 mdr SHALL hold its value in IDLE, LOAD and DONE.
REQ-033 ld_start in RUN SHALL transition to LOAD, raising cpu_hold on the next edge; in LOAD or DONE, ld_start SHALL be ignored.
REQ-034 Read latency from an address change to mdr SHALL be one rising edge.

Reset
REQ-035 rst=1 SHALL asynchronously force: state=IDLE, mdr=0x00, ptr=0, count=0, ld_done=0, ld_ready=0, cpu_hold=1.
REQ-036 rst asserted mid-LOAD SHALL abort the load, keep the already-written bytes, and return to IDLE.

Verification
REQ-037 A bench SHALL check: reset, then ld_start with ld_len=3 and bytes 0xA1, 0xB2, 0xC3 with valid held high -> ld_ready=1 for 3 cycles, ld_done pulses once, cpu_hold falls one cycle later, and mem[0..2]=A1, B2, C3.
REQ-038 A bench SHALL check: ld_len=0 streaming 256 bytes of value i -> DONE only after the 256th byte, ptr wraps to 0, and mem[255]=0xFF.
REQ-039 A bench SHALL check: in RUN, fetch=1 with pc=0x02 -> mdr=0xC3 after one edge; fetch=0 with opaddr=0x01 -> mdr=0xB2.
REQ-040 A bench SHALL check: in RUN, fetch=0, store_mem=1, opaddr=0x10, wdata=0x5A over 2 cycles -> first mdr=old mem[0x10], second mdr=0x5A; the same stimulus with fetch=1 -> no write.
REQ-041 A bench SHALL check: ld_valid toggling 1, 0, 0, 1 with ld_len=2 -> exactly 2 writes, with ptr holding during the gaps.
REQ-042 A bench SHALL check: rst pulsed after 1 of 3 load bytes -> state=IDLE, mdr=0, cpu_hold=1, and mem[0] retained; then boot_skip -> RUN with cpu_hold=0.

Source files
------------

// File: rtl/mem_unit.sv
// mem_unit: 256x8 program/data memory with a boot loader front end.
//
// After reset the block sits in IDLE holding the CPU in reset (cpu_hold=1).
// A program is streamed in through the ld_* handshake starting at address 0.
// Alternatively, boot_skip goes straight to RUN and uses the existing contents.
// In RUN the CPU reads through mdr (one-edge latency, address = fetch ? pc : opaddr)
// and writes accumulator data with store_mem.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset (array contents are kept)
//   fetch      in   address select: 1 = pc, 0 = opaddr
//   store_mem  in   write request, honoured in RUN only when fetch=0
//   pc         in   [7:0] program-counter address
//   opaddr     in   [7:0] operand address
//   wdata      in   [7:0] write data
//   mdr        out  [7:0] registered read data, updated only in RUN
//   ld_start   in   start a load at address 0 (accepted in IDLE and RUN)
//   ld_len     in   [7:0] load length sampled with ld_start, 0 means 256
//   ld_valid   in   load byte valid
//   ld_data    in   [7:0] load byte
//   ld_ready   out  high while in LOAD
//   boot_skip  in   IDLE -> RUN without loading
//   cpu_hold   out  low only in RUN
//   ld_done    out  single-cycle pulse (the DONE state)
//   mstate     out  [1:0] IDLE=0, LOAD=1, DONE=2, RUN=3
module mem_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       fetch,
  input  logic       store_mem,
  input  logic [7:0] pc,
  input  logic [7:0] opaddr,
  input  logic [7:0] wdata,
  output logic [7:0] mdr,
  input  logic       ld_start,
  input  logic [7:0] ld_len,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  input  logic       boot_skip,
  output logic       cpu_hold,
  output logic       ld_done,
  output logic [1:0] mstate
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    RUN  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [7:0] mem [0:255];
  logic [7:0] ptr;
  // 9 bits so a 256-byte load can be represented
  logic [8:0] count;

  logic [7:0] addr;
  logic       ld_accept;
  logic       run_write;
  logic       enter_load;

  assign addr       = fetch ? pc : opaddr;
  assign ld_accept  = (state == LOAD) && ld_valid;
  assign run_write  = (state == RUN) && store_mem && !fetch;
  assign enter_load = (state != LOAD) && (state_nxt == LOAD);

  // Status outputs decode straight from the state register, so reset
  // forces them along with the state.
  assign ld_ready = (state == LOAD);
  assign ld_done  = (state == DONE);
  assign cpu_hold = (state != RUN);
  assign mstate   = state;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (ld_start)       state_nxt = LOAD;
        else if (boot_skip) state_nxt = RUN;
      end
      LOAD: begin
        if (ld_valid && (count == 9'd1)) state_nxt = DONE;
      end
      DONE:    state_nxt = RUN;
      RUN: begin
        if (ld_start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      count <= '0;
      mdr   <= '0;
    end else begin
      state <= state_nxt;
      if (enter_load) begin
        ptr   <= '0;
        count <= (ld_len == '0) ? 9'd256 : {1'b0, ld_len};
      end else if (ld_accept) begin
        ptr   <= ptr + 8'd1;
        count <= count - 9'd1;
      end
      // Read-before-write: this samples the array before the write below lands.
      if (state == RUN) mdr <= mem[addr];
    end
  end

  // Storage has no reset so a warm reset keeps the loaded program.
  always_ff @(posedge clk) begin
    if (ld_accept)      mem[ptr]    <= ld_data;
    else if (run_write) mem[opaddr] <= wdata;
  end

endmodule

// File: tb/tb_mem_unit.sv
module tb_mem_unit;

  logic       clk = 1'b0;
  logic       rst, fetch, store_mem, ld_start, ld_valid, boot_skip;
  logic [7:0] pc, opaddr, wdata, ld_len, ld_data;
  logic [7:0] mdr;
  logic       ld_ready, cpu_hold, ld_done;
  logic [1:0] mstate;

  int ntests = 0;
  int nfail  = 0;

  logic [7:0] model_mem [256];

  mem_unit dut (
    .clk(clk), .rst(rst), .fetch(fetch), .store_mem(store_mem),
    .pc(pc), .opaddr(opaddr), .wdata(wdata), .mdr(mdr),
    .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .boot_skip(boot_skip),
    .cpu_hold(cpu_hold), .ld_done(ld_done), .mstate(mstate)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic f, input logic [7:0] a, input logic [7:0] exp, input string nm);
    fetch = f; pc = a; opaddr = a; store_mem = 1'b0;
    tick();
    chk(nm, 32'(mdr), 32'(exp));
  endtask

  typedef struct {
    logic       fetch;
    logic       store;
    logic [7:0] pc;
    logic [7:0] opaddr;
    logic [7:0] wdata;
    logic [7:0] exp_mdr;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int ready_cnt, done_cnt, early;
    logic [7:0] mdr_hold;
    logic [7:0] bytes3 [3];
    logic       vpat [4];
    logic [7:0] ptr_exp [4];

    rst = 1'b1; fetch = 1'b0; store_mem = 1'b0; pc = '0; opaddr = '0; wdata = '0;
    ld_start = 1'b0; ld_len = '0; ld_valid = 1'b0; ld_data = '0; boot_skip = 1'b0;

    // Reset is asynchronous: outputs settle before the first clock edge.
    #2;
    chk("rst_state",    32'(mstate),   32'd0);
    chk("rst_mdr",      32'(mdr),      32'h00);
    chk("rst_hold",     32'(cpu_hold), 32'd1);
    chk("rst_ready",    32'(ld_ready), 32'd0);
    chk("rst_done",     32'(ld_done),  32'd0);
    chk("rst_ptr",      32'(dut.ptr),  32'd0);
    chk("rst_count",    32'(dut.count), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("idle_stays",   32'(mstate),   32'd0);

    // 256-byte load (ld_len=0); ld_start must win over boot_skip.
    ld_start = 1'b1; ld_len = 8'd0; boot_skip = 1'b1;
    tick();
    chk("l256_enter",   32'(mstate),   32'd1);
    chk("l256_ready",   32'(ld_ready), 32'd1);
    chk("l256_ptr0",    32'(dut.ptr),  32'd0);
    ld_start = 1'b0; boot_skip = 1'b0; ld_valid = 1'b1;
    early = 0;
    for (int i = 0; i < 256; i++) begin
      ld_data = 8'(i);
      tick();
      model_mem[i] = 8'(i);
      if (i < 255 && mstate != 2'd1) early++;
      if (i == 254) chk("l256_ptr255", 32'(dut.ptr), 32'd255);
    end
    chk("l256_no_early_done", 32'(early), 32'd0);
    chk("l256_done_state", 32'(mstate),  32'd2);
    chk("l256_done_pulse", 32'(ld_done), 32'd1);
    chk("l256_ptr_wrap",   32'(dut.ptr), 32'd0);
    chk("l256_hold_done",  32'(cpu_hold), 32'd1);
    ld_valid = 1'b0;
    tick();
    chk("l256_run",        32'(mstate),  32'd3);
    chk("l256_run_hold",   32'(cpu_hold), 32'd0);
    rd(1'b1, 8'hFF, 8'hFF, "l256_mem255");
    rd(1'b0, 8'h80, 8'h80, "l256_mem128");

    // Reset, then a 3-byte load with valid held high.
    rst = 1'b1;
    #1;
    chk("rst2_state", 32'(mstate),   32'd0);
    chk("rst2_hold",  32'(cpu_hold), 32'd1);
    rst = 1'b0;
    tick();
    ld_valid = 1'b1; ld_data = 8'h99;
    tick();
    chk("idle_ignores_valid", 32'(dut.ptr), 32'd0);
    ld_start = 1'b1; ld_len = 8'd3;
    tick();
    ld_start = 1'b0;
    bytes3[0] = 8'hA1; bytes3[1] = 8'hB2; bytes3[2] = 8'hC3;
    ready_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      ready_cnt += int'(ld_ready);
      ld_data = bytes3[i];
      tick();
      model_mem[i] = bytes3[i];
    end
    for (int k = 0; k < 3; k++) begin
      ready_cnt += int'(ld_ready);
      done_cnt  += int'(ld_done);
      if (k == 0) chk("l3_hold_in_done", 32'(cpu_hold), 32'd1);
      if (k == 1) chk("l3_hold_fell",    32'(cpu_hold), 32'd0);
      ld_valid = 1'b0;
      tick();
    end
    chk("l3_ready_cycles", 32'(ready_cnt), 32'd3);
    chk("l3_done_pulses",  32'(done_cnt),  32'd1);

    // Table of RUN-mode reads/writes over the known contents.
    vecs[0] = '{1'b1, 1'b0, 8'h02, 8'h00, 8'h00, 8'hC3};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 8'hB2};
    vecs[2] = '{1'b1, 1'b0, 8'h00, 8'h07, 8'h00, 8'hA1};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h10, 8'h5A, 8'h10};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h10, 8'h5A, 8'h5A};
    vecs[5] = '{1'b1, 1'b1, 8'h20, 8'h20, 8'h77, 8'h20};
    vecs[6] = '{1'b1, 1'b1, 8'h20, 8'h20, 8'h77, 8'h20};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 8'h20, 8'h00, 8'h20};
    vecs[8] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 8'h5A};
    for (int v = 0; v < 9; v++) begin
      fetch = vecs[v].fetch; store_mem = vecs[v].store;
      pc = vecs[v].pc; opaddr = vecs[v].opaddr; wdata = vecs[v].wdata;
      tick();
      chk($sformatf("vec%0d_mdr", v), 32'(mdr), 32'(vecs[v].exp_mdr));
      if (vecs[v].store && !vecs[v].fetch) model_mem[vecs[v].opaddr] = vecs[v].wdata;
    end
    store_mem = 1'b0;

    // Random RUN traffic against the array model (read sees pre-write data).
    for (int n = 0; n < 300; n++) begin
      logic       f, st;
      logic [7:0] pa, oa, wd, exp;
      f  = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 2) == 0);
      oa = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      pa = ($urandom_range(0, 3) == 0) ? oa : 8'($urandom_range(0, 255));
      wd = 8'($urandom_range(0, 255));
      fetch = f; store_mem = st; pc = pa; opaddr = oa; wdata = wd;
      exp = model_mem[f ? pa : oa];
      tick();
      chk($sformatf("rand%0d_mdr", n), 32'(mdr), 32'(exp));
      if (st && !f) model_mem[oa] = wd;
    end
    store_mem = 1'b0;

    // ld_len=2 with gaps; ld_start during LOAD and DONE must be ignored.
    ld_start = 1'b1; ld_len = 8'd2; fetch = 1'b0;
    tick();
    chk("gap_enter_load", 32'(mstate),   32'd1);
    chk("gap_hold_rises", 32'(cpu_hold), 32'd1);
    mdr_hold = mdr;
    ld_start = 1'b0;
    vpat[0] = 1'b1; vpat[1] = 1'b0; vpat[2] = 1'b0; vpat[3] = 1'b1;
    ptr_exp[0] = 8'd1; ptr_exp[1] = 8'd1; ptr_exp[2] = 8'd1; ptr_exp[3] = 8'd2;
    for (int i = 0; i < 4; i++) begin
      ld_valid = vpat[i];
      ld_data  = (i == 0) ? 8'hD0 : ((i == 3) ? 8'hD1 : 8'hEE);
      ld_start = !vpat[i];
      ld_len   = 8'd7;
      tick();
      chk($sformatf("gap%0d_ptr", i), 32'(dut.ptr), 32'(ptr_exp[i]));
    end
    chk("gap_done_state", 32'(mstate), 32'd2);
    model_mem[0] = 8'hD0; model_mem[1] = 8'hD1;
    ld_valid = 1'b0; ld_start = 1'b1;
    tick();
    chk("done_ignores_start", 32'(mstate), 32'd3);
    chk("mdr_held_in_load",   32'(mdr),    32'(mdr_hold));
    ld_start = 1'b0;
    rd(1'b1, 8'h00, model_mem[0], "gap_mem0");
    rd(1'b1, 8'h01, model_mem[1], "gap_mem1");
    rd(1'b0, 8'h02, model_mem[2], "gap_mem2_untouched");

    // Reset during a load: written byte kept, then boot_skip into RUN.
    ld_start = 1'b1; ld_len = 8'd3;
    tick();
    chk("abort_hold_rises", 32'(cpu_hold), 32'd1);
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 8'hE0;
    tick();
    chk("abort_ptr1", 32'(dut.ptr), 32'd1);
    model_mem[0] = 8'hE0;
    ld_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("abort_state", 32'(mstate),   32'd0);
    chk("abort_mdr",   32'(mdr),      32'h00);
    chk("abort_hold",  32'(cpu_hold), 32'd1);
    chk("abort_ready", 32'(ld_ready), 32'd0);
    chk("abort_ptr",   32'(dut.ptr),  32'd0);
    #1 rst = 1'b0;
    boot_skip = 1'b1;
    tick();
    chk("skip_run",  32'(mstate),   32'd3);
    chk("skip_hold", 32'(cpu_hold), 32'd0);
    boot_skip = 1'b0;
    rd(1'b1, 8'h00, model_mem[0], "abort_mem0_kept");
    rd(1'b0, 8'h01, model_mem[1], "abort_mem1_kept");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
